// File: rtl/pkt_bus_pkg.sv
// Shared packet-bus definitions: 134-bit word layout, flag encodings and the
// state types used by the output buffer.
package pkt_bus_pkg;

    localparam int unsigned PKT_W   = 134;
    localparam int unsigned FLAG_HI = 133;
    localparam int unsigned FLAG_LO = 132;

    typedef logic [1:0] flag_t;

    localparam flag_t FLAG_HEAD = 2'b01;
    localparam flag_t FLAG_BODY = 2'b11;
    localparam flag_t FLAG_TAIL = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_BODY, W_WAIT} wstate_e;
    typedef enum logic       {R_IDLE, R_SEND}         rstate_e;

    function automatic flag_t pkt_flag(input logic [PKT_W-1:0] w);
        return w[FLAG_HI:FLAG_LO];
    endfunction

endpackage

// File: rtl/pkt_out_buf_if.sv
// Packet word bus with per-packet validity strobe and a whole-packet ready.
interface pkt_out_buf_if;
    import pkt_bus_pkg::*;

    logic             data_wr;
    logic [PKT_W-1:0] data;
    logic             data_valid_wr;
    logic             data_valid;
    logic             ready;

    modport master (output data_wr, data, data_valid_wr, data_valid, input ready);
    modport slave  (input data_wr, data, data_valid_wr, data_valid, output ready);

endinterface

// File: rtl/pkt_out_buf_ram.sv
// Simple dual-port RAM, one write port and one read port with registered read data.
module sdp_ram #(
    parameter int unsigned AW = 8,
    parameter int unsigned W  = 134
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [1 << AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_out_buf.sv
// Store-and-forward output buffer: packets are written speculatively, committed or
// rolled back at their validity strobe, and only complete packets are forwarded.
module pkt_out_buf
    import pkt_bus_pkg::*;
#(
    parameter int unsigned AW            = 8,
    parameter int unsigned MAX_PKT_WORDS = 98,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    pkt_out_buf_if.slave     in_if,
    pkt_out_buf_if.master    out_if,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t DEPTH_P = ptr_t'(1 << AW);
    localparam ptr_t MAX_P   = ptr_t'(MAX_PKT_WORDS);

    wstate_e          wstate_q, wstate_d;
    rstate_e          rstate_q, rstate_d;
    ptr_t             wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
    ptr_t             avail_q, free;
    logic             poison_q, poison_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] drop_q, fwd_q;
    logic             out_wr_q, out_vwr_q;
    logic [PKT_W-1:0] out_data_q, rdata;
    logic             we, re, drop_inc, commit, start, store, tail_in, send, tail_out;
    logic [AW-1:0]    waddr, raddr;
    logic             wr_head, wr_body, wr_tail;

    function automatic logic is_full(input ptr_t p, input ptr_t r);
        return AW'(p[AW-1:0] + AW'(1)) == r[AW-1:0];
    endfunction

    assign wr_head = in_if.data_wr && (pkt_flag(in_if.data) == FLAG_HEAD);
    assign wr_body = in_if.data_wr && (pkt_flag(in_if.data) == FLAG_BODY);
    assign wr_tail = in_if.data_wr && (pkt_flag(in_if.data) == FLAG_TAIL);
    assign free    = DEPTH_P - (wptr_q - rptr_q);

    // Pending-packet resolution in W_WAIT happens before a new head is placed;
    // a same-cycle tail strobe is resolved after the tail word itself is written.
    always_comb begin
        wstate_d = wstate_q;
        wptr_d   = wptr_q;
        cptr_d   = cptr_q;
        poison_d = poison_q;
        we       = 1'b0;
        waddr    = wptr_q[AW-1:0];
        drop_inc = 1'b0;
        commit   = 1'b0;
        start    = 1'b0;
        store    = 1'b0;
        tail_in  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (wr_head) start = 1'b1;
                else if (in_if.data_wr) drop_inc = 1'b1;
            end
            W_BODY: begin
                if (wr_head) begin
                    drop_inc = 1'b1;
                    wptr_d   = cptr_q;
                    start    = 1'b1;
                end else if (wr_body) begin
                    store = 1'b1;
                end else if (wr_tail) begin
                    store   = 1'b1;
                    tail_in = 1'b1;
                end
            end
            W_WAIT: begin
                if (in_if.data_valid_wr) begin
                    wstate_d = W_IDLE;
                    if (in_if.data_valid && !poison_q) begin
                        commit = 1'b1;
                        cptr_d = wptr_q;
                    end else begin
                        drop_inc = 1'b1;
                        wptr_d   = cptr_q;
                    end
                end else if (wr_head) begin
                    drop_inc = 1'b1;
                    wptr_d   = cptr_q;
                end
                if (wr_head) start = 1'b1;
            end
            default: wstate_d = W_IDLE;
        endcase
        if (start) begin
            poison_d = 1'b0;
            wstate_d = W_BODY;
        end
        if (start || store) begin
            waddr = wptr_d[AW-1:0];
            if (is_full(wptr_d, rptr_q)) begin
                poison_d = 1'b1;
            end else begin
                we     = 1'b1;
                wptr_d = wptr_d + PTR_ONE;
            end
        end
        if (tail_in) begin
            if (in_if.data_valid_wr) begin
                wstate_d = W_IDLE;
                if (in_if.data_valid && !poison_d) begin
                    commit = 1'b1;
                    cptr_d = wptr_d;
                end else begin
                    drop_inc = 1'b1;
                    wptr_d   = cptr_q;
                end
            end else begin
                wstate_d = W_WAIT;
            end
        end
    end

    // The word under inspection in R_SEND is the one read in the previous cycle,
    // so reading stops exactly at the tail without over-fetching.
    always_comb begin
        rstate_d = rstate_q;
        rptr_d   = rptr_q;
        re       = 1'b0;
        raddr    = rptr_q[AW-1:0];
        send     = 1'b0;
        tail_out = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (avail_q != '0 && out_if.ready) begin
                    re       = 1'b1;
                    rptr_d   = rptr_q + PTR_ONE;
                    rstate_d = R_SEND;
                end
            end
            R_SEND: begin
                send = 1'b1;
                if (pkt_flag(rdata) == FLAG_TAIL) begin
                    tail_out = 1'b1;
                    rstate_d = R_IDLE;
                end else begin
                    re     = 1'b1;
                    rptr_d = rptr_q + PTR_ONE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            wptr_q     <= '0;
            cptr_q     <= '0;
            rptr_q     <= '0;
            poison_q   <= 1'b0;
            avail_q    <= '0;
            in_ready_q <= 1'b0;
            drop_q     <= '0;
            fwd_q      <= '0;
            out_wr_q   <= 1'b0;
            out_vwr_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            wptr_q     <= wptr_d;
            cptr_q     <= cptr_d;
            rptr_q     <= rptr_d;
            poison_q   <= poison_d;
            in_ready_q <= (free >= MAX_P) && (avail_q != '1);
            out_wr_q   <= send;
            out_vwr_q  <= tail_out;
            if (send) out_data_q <= rdata;
            if (commit && !tail_out && avail_q != '1) avail_q <= avail_q + PTR_ONE;
            else if (tail_out && !commit)             avail_q <= avail_q - PTR_ONE;
            if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            if (tail_out && fwd_q != '1)  fwd_q  <= fwd_q + CNT_W'(1);
        end
    end

    sdp_ram #(.AW(AW), .W(PKT_W)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (in_if.data),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign in_if.ready          = in_ready_q;
    assign out_if.data_wr       = out_wr_q;
    assign out_if.data          = out_data_q;
    assign out_if.data_valid_wr = out_vwr_q;
    assign out_if.data_valid    = out_vwr_q;
    assign drop_cnt             = drop_q;
    assign fwd_cnt              = fwd_q;

endmodule

// File: tb/tb_pkt_out_buf.sv
// Scoreboard bench for pkt_out_buf: committed packets are queued word by word and
// compared against the output stream, with counters and ready checked per scenario.
module tb_pkt_out_buf;
    import pkt_bus_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned MAXW  = 98;
    localparam int unsigned CNT_W = 32;
    localparam int          CAP   = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_out_buf_if in_if ();
    pkt_out_buf_if out_if ();
    logic [CNT_W-1:0] drop_cnt, fwd_cnt;

    pkt_out_buf #(.AW(AW), .MAX_PKT_WORDS(MAXW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_if    (in_if),
        .out_if   (out_if),
        .drop_cnt (drop_cnt),
        .fwd_cnt  (fwd_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int used_words = 0;
    int exp_drop = 0;
    int exp_fwd = 0;
    int pkt_id = 0;
    int t_tail = 0;
    int last_tail_cyc = -10;
    int last_head_cyc = -1;
    logic [PKT_W-1:0] sb[$];
    logic [PKT_W-1:0] exp_w;
    logic [PKT_W-1:0] head1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_if.data_wr) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_w = sb.pop_front();
                used_words--;
                check("out_data", out_if.data, exp_w);
                check("out_valid_wr", out_if.data_valid_wr, exp_w[133:132] == FLAG_TAIL);
                check("out_valid", out_if.data_valid, exp_w[133:132] == FLAG_TAIL);
                if (exp_w[133:132] == FLAG_HEAD) begin
                    check("pkt_gap", (cyc - last_tail_cyc) >= 2, 1);
                    last_head_cyc = cyc;
                end
                if (exp_w[133:132] == FLAG_TAIL) last_tail_cyc = cyc;
            end
        end
    end

    // abort_after > 0 sends only that many leading words and no tail
    task automatic send_pkt(input int n, input logic keep, input logic [PKT_W-1:0] head_w,
                            input int abort_after, input logic force_in);
        logic [PKT_W-1:0] w;
        logic [PKT_W-1:0] words[$];
        flag_t fl;
        int b;
        if (!force_in) begin
            b = 0;
            while (!in_if.ready && b < 2000) begin
                @(posedge clk); #1;
                b++;
            end
            if (b >= 2000) check("in_ready_wait", in_if.ready, 1);
        end
        pkt_id++;
        for (int i = 0; i < n; i++) begin
            if (abort_after != 0 && i == abort_after) break;
            fl = (i == 0) ? FLAG_HEAD : (i == n - 1) ? FLAG_TAIL : FLAG_BODY;
            w = {fl, 4'hf, 32'(pkt_id), 32'(i), $urandom(), $urandom()};
            if (i == 0 && head_w != '0) w = head_w;
            in_if.data_wr       = 1'b1;
            in_if.data          = w;
            in_if.data_valid_wr = (i == n - 1);
            in_if.data_valid    = keep;
            words.push_back(w);
            @(posedge clk); #1;
        end
        in_if.data_wr       = 1'b0;
        in_if.data_valid_wr = 1'b0;
        in_if.data_valid    = 1'b0;
        t_tail = cyc;
        if (abort_after == 0 && keep && used_words + n <= CAP) begin
            foreach (words[k]) sb.push_back(words[k]);
            used_words += n;
            exp_fwd++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic drain(input string tag);
        int b = 0;
        while (sb.size() != 0 && b < 3000) begin
            @(posedge clk); #1;
            b++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    initial begin
        in_if.data_wr       = 1'b0;
        in_if.data          = '0;
        in_if.data_valid_wr = 1'b0;
        in_if.data_valid    = 1'b0;
        out_if.ready        = 1'b0;
        rst                 = 1'b1;
        head1 = {2'b01, 24'hff, 12'd96, 96'hff};
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_if.ready, 0);
        check("rst_out_wr", out_if.data_wr, 0);
        check("rst_out_data", out_if.data, 0);
        check("rst_out_vwr", out_if.data_valid_wr, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_fwd", fwd_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", in_if.ready, 1);

        // single six-word packet, valid with the tail
        out_if.ready = 1'b1;
        send_pkt(6, 1'b1, head1, 0, 1'b0);
        drain("t1_drain");
        check("t1_latency", last_head_cyc - t_tail, 2);
        check("t1_fwd", fwd_cnt, exp_fwd);

        // same packet marked invalid
        send_pkt(6, 1'b0, head1, 0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("t2_drop", drop_cnt, exp_drop);
        check("t2_fwd", fwd_cnt, exp_fwd);
        check("t2_ready", in_if.ready, 1);

        // two packets held, then released
        out_if.ready = 1'b0;
        send_pkt(10, 1'b1, '0, 0, 1'b0);
        send_pkt(7, 1'b1, '0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("t3_held", sb.size(), 17);
        check("t3_fwd_held", fwd_cnt, 1);
        out_if.ready = 1'b1;
        drain("t3_drain");
        check("t3_fwd", fwd_cnt, exp_fwd);

        // fill with max-size packets, then force an overflowing one
        out_if.ready = 1'b0;
        send_pkt(MAXW, 1'b1, '0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_ready1", in_if.ready, (CAP + 1 - used_words) >= MAXW);
        send_pkt(MAXW, 1'b1, '0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_ready2", in_if.ready, (CAP + 1 - used_words) >= MAXW);
        send_pkt(MAXW, 1'b1, '0, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_ovf_drop", drop_cnt, exp_drop);
        check("t4_ovf_ready", in_if.ready, 0);
        out_if.ready = 1'b1;
        drain("t4_drain");
        check("t4_fwd", fwd_cnt, exp_fwd);
        check("t4_ready3", in_if.ready, 1);

        // head, two bodies, then a new head without a tail
        send_pkt(10, 1'b1, '0, 3, 1'b0);
        send_pkt(8, 1'b1, '0, 0, 1'b0);
        drain("t5_drain");
        check("t5_drop", drop_cnt, exp_drop);
        check("t5_fwd", fwd_cnt, exp_fwd);

        // reset while both sides are mid-packet
        send_pkt(30, 1'b1, '0, 0, 1'b0);
        send_pkt(20, 1'b1, '0, 5, 1'b0);
        rst = 1'b1;
        sb.delete();
        used_words    = 0;
        exp_drop      = 0;
        exp_fwd       = 0;
        last_tail_cyc = -10;
        #1;
        check("t6_rst_out_wr", out_if.data_wr, 0);
        check("t6_rst_out_data", out_if.data, 0);
        check("t6_rst_out_vwr", out_if.data_valid_wr, 0);
        check("t6_rst_ready", in_if.ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_ready", in_if.ready, 1);
        check("t6_drop0", drop_cnt, 0);
        check("t6_fwd0", fwd_cnt, 0);
        send_pkt(12, 1'b1, '0, 0, 1'b0);
        drain("t6_drain");
        check("t6_fwd", fwd_cnt, exp_fwd);
        check("t6_drop", drop_cnt, exp_drop);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
